ham74_tx: RTL and testbench

Hamming(7,4) encoder plus serial transmitter. It is the sending end of the `ham74` link. It accepts a 4-bit data nibble through a start/ready handshake and computes the 7-bit codeword in the same bit layout the receiving-side corrector expects. It then shifts the codeword out on a single line inside a start/stop framed character.

---
 rtl/ham74_tx.sv | 145 ++++++++++++++
 tb/tb_ham74_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ham74_tx.sv
// Hamming(7,4) encoder and start/stop framed serial transmitter for the ham74 link.
// Optional build macro HAM74_ERR_INJECT_EN adds err_pos for single-bit error injection.
module ham74_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] data,
    input  logic       start,
`ifdef HAM74_ERR_INJECT_EN
    input  logic [2:0] err_pos,
`endif
    output logic       ready,
    output logic       busy,
    output logic       tx,
    output logic [6:0] codeword,
    output logic       done
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    sreg_q, sreg_d;
    logic [6:0]    cw_q, cw_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [6:0]    enc;
    logic          bit_end;

    // Layout {d4,d3,d2,p3,d1,p2,p1} matches the receiving corrector.
    always_comb begin
        enc = {data[3], data[2], data[1], data[1] ^ data[2] ^ data[3],
               data[0], data[0] ^ data[2] ^ data[3], data[0] ^ data[1] ^ data[3]};
`ifdef HAM74_ERR_INJECT_EN
        if (err_pos != 3'd0) begin
            enc = enc ^ (7'b0000001 << (err_pos - 3'd1));
        end
`endif
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        cw_d    = cw_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    sreg_d  = enc;
                    cw_d    = enc;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    tx_d    = sreg_q[0];
                    sreg_d  = {1'b0, sreg_q[6:1]};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd6) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        tx_d   = sreg_q[0];
                        sreg_d = {1'b0, sreg_q[6:1]};
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            cw_q    <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            cw_q    <= cw_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign tx       = tx_q;
    assign codeword = cw_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ham74_tx.sv
// Bench for ham74_tx: random nibbles checked against a positional Hamming model and frame timeline.
// Build with HAM74_ERR_INJECT_EN defined to also cover the err_pos injection path.
module tb_ham74_tx;

    localparam int unsigned C = 4;

    logic       clock;
    logic       reset;
    logic [3:0] data;
    logic       start;
    logic       ready;
    logic       busy;
    logic       tx;
    logic [6:0] codeword;
    logic       done;
`ifdef HAM74_ERR_INJECT_EN
    logic [2:0] err_pos;
`endif

    int checks = 0;
    int errors = 0;

    ham74_tx #(.CLKS_PER_BIT(C)) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data),
        .start    (start),
`ifdef HAM74_ERR_INJECT_EN
        .err_pos  (err_pos),
`endif
        .ready    (ready),
        .busy     (busy),
        .tx       (tx),
        .codeword (codeword),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Codeword position i (1..7) lives in bit i-1; parity sits at power-of-two positions.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [7:0] pos;
        pos    = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int j = 0; j < 3; j++) begin
            for (int i = 1; i < 8; i++) begin
                if (((i >> j) & 1) == 1 && i != (1 << j)) pos[1 << j] ^= pos[i];
            end
        end
        return pos[7:1];
    endfunction

    function automatic logic [2:0] ref_syndrome(input logic [6:0] cw);
        logic [2:0] s;
        s = '0;
        for (int i = 1; i < 8; i++) if (cw[i-1]) s ^= 3'(i);
        return s;
    endfunction

    function automatic logic [3:0] ref_extract(input logic [6:0] cw);
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

    task automatic set_err(input logic [2:0] ep);
`ifdef HAM74_ERR_INJECT_EN
        err_pos = ep;
`else
        if (ep != 3'd0) $display("note: err_pos ignored in this build");
`endif
    endtask

    // Entered and left at a negedge; leaves the bench in the done cycle.
    task automatic run_frame(input logic [3:0] d, input logic [2:0] ep, input bit hold, input bit noise);
        logic [6:0] exp_cw;
        logic       exp_tx;
        int unsigned slot;
        exp_cw = ref_encode(d);
        if (ep != 3'd0) exp_cw[ep - 3'd1] = ~exp_cw[ep - 3'd1];
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_pre ready=%b exp=1", ready); end
        data  = d;
        start = 1'b1;
        set_err(ep);
        @(posedge clock);
        #1;
        if (!hold) start = 1'b0;
        data = 4'($urandom);
        set_err(3'($urandom));
        for (int k = 0; k < int'(9 * C); k++) begin
            @(negedge clock);
            slot = k / C;
            if (slot == 0) exp_tx = 1'b0;
            else if (slot == 8) exp_tx = 1'b1;
            else exp_tx = exp_cw[slot - 1];
            checks += 5;
            if (tx !== exp_tx) begin errors++; $display("FAIL frame_tx k=%0d tx=%b exp=%b", k, tx, exp_tx); end
            if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy k=%0d busy=%b exp=1", k, busy); end
            if (ready !== 1'b0) begin errors++; $display("FAIL frame_ready k=%0d ready=%b exp=0", k, ready); end
            if (done !== 1'b0) begin errors++; $display("FAIL frame_done k=%0d done=%b exp=0", k, done); end
            if (codeword !== exp_cw) begin errors++; $display("FAIL frame_cw k=%0d cw=%h exp=%h", k, codeword, exp_cw); end
            if (noise) start = 1'($urandom);
        end
        start = hold;
        @(negedge clock);
        checks += 5;
        if (done !== 1'b1) begin errors++; $display("FAIL end_done done=%b exp=1", done); end
        if (ready !== 1'b1) begin errors++; $display("FAIL end_ready ready=%b exp=1", ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL end_busy busy=%b exp=0", busy); end
        if (tx !== 1'b1) begin errors++; $display("FAIL end_tx tx=%b exp=1", tx); end
        if (codeword !== exp_cw) begin errors++; $display("FAIL end_cw cw=%h exp=%h", codeword, exp_cw); end
    endtask

    task automatic idle_check(input int n, input logic [6:0] exp_cw, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checks += 5;
            if (tx !== 1'b1) begin errors++; $display("FAIL %s_tx i=%0d tx=%b exp=1", tag, i, tx); end
            if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready i=%0d ready=%b exp=1", tag, i, ready); end
            if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy i=%0d busy=%b exp=0", tag, i, busy); end
            if (done !== 1'b0) begin errors++; $display("FAIL %s_done i=%0d done=%b exp=0", tag, i, done); end
            if (codeword !== exp_cw) begin errors++; $display("FAIL %s_cw i=%0d cw=%h exp=%h", tag, i, codeword, exp_cw); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        data  = 4'd0;
        set_err(3'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle_check(10, 7'h00, "reset_idle");
    endtask

    task automatic test_known_frame();
        run_frame(4'b1011, 3'd0, 1'b0, 1'b0);
        checks++;
        if (codeword !== 7'h55) begin errors++; $display("FAIL known_cw cw=%h exp=55", codeword); end
        idle_check(2, 7'h55, "known_idle");
    endtask

    task automatic test_encode_sweep();
        logic [6:0] lit [3];
        logic [3:0] lit_d [3];
        lit[0] = 7'h00; lit_d[0] = 4'b0000;
        lit[1] = 7'h07; lit_d[1] = 4'b0001;
        lit[2] = 7'h7F; lit_d[2] = 4'b1111;
        for (int n = 0; n < 16; n++) begin
            run_frame(4'(n), 3'd0, 1'b0, 1'b0);
            checks += 2;
            if (ref_syndrome(codeword) !== 3'd0) begin
                errors++; $display("FAIL sweep_syn d=%h syn=%0d exp=0", n, ref_syndrome(codeword));
            end
            if (ref_extract(codeword) !== 4'(n)) begin
                errors++; $display("FAIL sweep_data d=%h got=%h exp=%h", n, ref_extract(codeword), n);
            end
            for (int j = 0; j < 3; j++) begin
                if (lit_d[j] == 4'(n)) begin
                    checks++;
                    if (codeword !== lit[j]) begin errors++; $display("FAIL sweep_lit d=%h cw=%h exp=%h", n, codeword, lit[j]); end
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        for (int f = 0; f < 4; f++) begin
            d = 4'($urandom);
            run_frame(d, 3'd0, f != 3, 1'b0);
        end
        idle_check(3, ref_encode(d), "b2b_idle");
    endtask

    task automatic test_busy_ignored();
        logic [3:0] d;
        for (int f = 0; f < 3; f++) begin
            d = 4'($urandom);
            run_frame(d, 3'd0, 1'b0, 1'b1);
            idle_check(2, ref_encode(d), "noise_idle");
        end
    endtask

    task automatic test_reset_mid();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL mid_pre ready=%b exp=1", ready); end
        data  = 4'b1011;
        start = 1'b1;
        set_err(3'd0);
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4 * C + 2) @(negedge clock);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 tx=%b exp=0", tx); end
        #1;
        reset = 1'b1;
        #1;
        checks += 4;
        if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx tx=%b exp=1", tx); end
        if (ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready ready=%b exp=1", ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy busy=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_async_done done=%b exp=0", done); end
        @(negedge clock);
        reset = 1'b0;
        idle_check(9 * C + 4, 7'h00, "mid_after");
    endtask

`ifdef HAM74_ERR_INJECT_EN
    task automatic test_err_inject();
        logic [3:0] d;
        logic [2:0] ep;
        logic [6:0] fixed;
        run_frame(4'b1011, 3'd3, 1'b0, 1'b0);
        checks++;
        if (codeword !== 7'h51) begin errors++; $display("FAIL inj_cw cw=%h exp=51", codeword); end
        @(negedge clock);
        for (int n = 0; n < 6; n++) begin
            d  = 4'($urandom);
            ep = 3'($urandom_range(0, 7));
            run_frame(d, ep, 1'b0, 1'b0);
            fixed = codeword;
            if (ref_syndrome(codeword) != 3'd0) fixed[ref_syndrome(codeword) - 3'd1] = ~fixed[ref_syndrome(codeword) - 3'd1];
            checks += 2;
            if (ref_syndrome(codeword) !== ep) begin
                errors++; $display("FAIL inj_syn d=%h ep=%0d syn=%0d", d, ep, ref_syndrome(codeword));
            end
            if (fixed !== ref_encode(d)) begin
                errors++; $display("FAIL inj_fix d=%h ep=%0d got=%h exp=%h", d, ep, fixed, ref_encode(d));
            end
            @(negedge clock);
        end
        set_err(3'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_known_frame();
        test_encode_sweep();
        test_back_to_back();
        test_busy_ignored();
        test_reset_mid();
`ifdef HAM74_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
